// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file slice:
//   - rf_state_t : controller states (IDLE = normal operation,
//                  CLEAR = sequential zeroing sweep in progress)
//   - DEF_*      : default parameter values used by regfile_mp and
//                  rf_scoreboard
// ---------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_N_RD   = 2;

endpackage

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// One pending bit per register, tracking registers that have been issued
// but not yet written back.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset (clears all)
//   set_en, set_idx   : mark set_idx pending
//   clr_en, clr_idx   : writeback to clr_idx, clears its pending bit
//   sweep_en/_idx     : clear-sweep zeroing of one pending bit per cycle
//   pending           : registered pending vector (bit 0 is always 0)
// ---------------------------------------------------------------------------
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_idx,
    input  logic                     clr_en,
    input  logic [ADDR_W-1:0]        clr_idx,
    input  logic                     sweep_en,
    input  logic [ADDR_W-1:0]        sweep_idx,
    output logic [(1<<ADDR_W)-1:0]   pending
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pending_next;

    // Clears are applied first so that a same-cycle set on the same
    // register wins and the register stays pending.
    always_comb begin
        pending_next = pending;
        if (clr_en)
            pending_next[clr_idx] = 1'b0;
        if (sweep_en)
            pending_next[sweep_idx] = 1'b0;
        if (set_en)
            pending_next[set_idx] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pending <= '0;
        else
            pending <= pending_next;
    end

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Multi-read-port register file with write-through bypass, a pending-
// writeback scoreboard and a sequential clear sweep.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   reg_write, write_reg,
//   write_data            : write port (register 0 is hardwired to zero)
//   read_reg, read_data   : N_RD combinational read ports, packed per port
//   read_pending          : pending bit of each port's addressed register
//   issue_valid, issue_reg: mark a register pending a writeback
//   clear_req             : start a sweep zeroing registers 1..DEPTH-1
//   busy                  : high while the sweep runs
// ---------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N_RD   = DEF_N_RD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reg_write,
    input  logic [ADDR_W-1:0]        write_reg,
    input  logic [DATA_W-1:0]        write_data,
    input  logic [N_RD*ADDR_W-1:0]   read_reg,
    output logic [N_RD*DATA_W-1:0]   read_data,
    output logic [N_RD-1:0]          read_pending,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_reg,
    input  logic                     clear_req,
    output logic                     busy
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_t          state;
    logic [ADDR_W-1:0]  sweep_idx;
    logic [DATA_W-1:0]  regs [DEPTH];
    logic [DEPTH-1:0]   pending;
    logic               sweeping;
    logic               commit_write;
    logic               issue_set;

    // Writes and issues are only honoured in IDLE; the sweep owns the
    // storage while it runs.
    assign sweeping     = (state == CLEAR);
    assign commit_write = (state == IDLE) && reg_write && (write_reg != '0);
    assign issue_set    = (state == IDLE) && issue_valid && (issue_reg != '0);
    assign busy         = sweeping;

    // Sweep controller: register 0 never needs clearing, so the sweep
    // starts at index 1 and finishes after index DEPTH-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sweep_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state     <= CLEAR;
                        sweep_idx <= ADDR_W'(1);
                    end
                end
                CLEAR: begin
                    if (sweep_idx == LAST_IDX) begin
                        state     <= IDLE;
                        sweep_idx <= '0;
                    end else begin
                        sweep_idx <= sweep_idx + ADDR_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    sweep_idx <= '0;
                end
            endcase
        end
    end

    // Storage. Entry 0 is never written, so it stays at its reset value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (commit_write) begin
            regs[write_reg] <= write_data;
        end else if (sweeping) begin
            regs[sweep_idx] <= '0;
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (issue_set),
        .set_idx   (issue_reg),
        .clr_en    (commit_write),
        .clr_idx   (write_reg),
        .sweep_en  (sweeping),
        .sweep_idx (sweep_idx),
        .pending   (pending)
    );

    // Read ports. The bypass is gated by reset so that reads stay zero
    // while reset is held even if a write is being presented.
    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit;

        assign addr = read_reg[k*ADDR_W +: ADDR_W];
        assign hit  = reset && commit_write && (write_reg == addr);

        assign read_data[k*DATA_W +: DATA_W] =
            (addr == '0) ? '0 : (hit ? write_data : regs[addr]);
        assign read_pending[k] = (addr != '0) && !hit && pending[addr];
    end

endmodule
